// File: rtl/sdram_wr_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sdram_wr_fifo_ctrl
//
// Write-side front end of the SDRAM controller. User words are buffered in a
// single-clock circular FIFO; once at least wr_burst_len words are stored
// (and SDRAM init is done) a burst request is raised towards the burst-write
// engine. The engine pops one word per ack cycle and the popped word is
// presented on sdram_wr_data one cycle later, lining up with the engine's
// data-enable. Burst start addresses auto-increment by wr_burst_len and wrap
// back to wr_b_addr inside the window [wr_b_addr, wr_e_addr).
//
// Optional build macro: SDRAM_WR_DROP_CNT_EN
//   When defined, adds wr_drop_cnt[15:0], a saturating count of pushes that
//   were dropped because the FIFO was full.
//
// Ports:
//   sys_clk          in   system clock
//   sys_rst_n        in   asynchronous active-low reset
//   init_end         in   SDRAM initialisation complete
//   wr_fifo_wr_en    in   user push strobe
//   wr_fifo_wr_data  in   user push data (32 bit)
//   wr_b_addr        in   window base address (inclusive)
//   wr_e_addr        in   window end address (exclusive)
//   wr_burst_len     in   words per burst (1..256, 0 disables requests)
//   wr_rst           in   address reload + FIFO flush request
//   sdram_wr_ack     in   engine ack, one word consumed per ack cycle
//   sdram_wr_end     in   engine burst-complete pulse
//   wr_fifo_full     out  FIFO full
//   wr_fifo_num      out  FIFO fill count
//   sdram_wr_req     out  burst request to the engine
//   sdram_wr_addr    out  burst start address {bank,row,col}
//   sdram_wr_data    out  word presented to the engine
//   wr_drop_cnt      out  dropped-push counter (SDRAM_WR_DROP_CNT_EN only)
// ---------------------------------------------------------------------------
module sdram_wr_fifo_ctrl #(
    parameter int FIFO_AW = 10
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               init_end,
    input  logic               wr_fifo_wr_en,
    input  logic [31:0]        wr_fifo_wr_data,
    input  logic [20:0]        wr_b_addr,
    input  logic [20:0]        wr_e_addr,
    input  logic [8:0]         wr_burst_len,
    input  logic               wr_rst,
    input  logic               sdram_wr_ack,
    input  logic               sdram_wr_end,
    output logic               wr_fifo_full,
    output logic [FIFO_AW:0]   wr_fifo_num,
    output logic               sdram_wr_req,
    output logic [20:0]        sdram_wr_addr,
    output logic [31:0]        sdram_wr_data
`ifdef SDRAM_WR_DROP_CNT_EN
   ,output logic [15:0]        wr_drop_cnt
`endif
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state;
    logic               rst_pend;
    logic               addr_load;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   num;

    logic               flush;
    logic               push;
    logic               pop;
    logic               burst_ready;
    logic [21:0]        nxt_addr;
    logic [21:0]        nxt_end;

    // num never exceeds DEPTH, so its MSB is set exactly when the FIFO is full.
    assign wr_fifo_full = num[FIFO_AW];
    assign wr_fifo_num  = num;

    // A flush only executes from IDLE; a wr_rst seen during REQ waits in
    // rst_pend so the in-flight burst still gets all of its data.
    assign flush = (state == IDLE) && (wr_rst || rst_pend);
    assign push  = wr_fifo_wr_en && !wr_fifo_full && !flush;
    assign pop   = sdram_wr_ack && (num != '0) && !flush;

    // Comparing at 32 bits keeps a burst length larger than the FIFO from
    // ever satisfying the threshold.
    assign burst_ready = init_end && (wr_burst_len != 9'd0) &&
                         (32'(num) >= 32'(wr_burst_len));

    // 22-bit sums so an address near the top of the map cannot alias low.
    assign nxt_addr = {1'b0, sdram_wr_addr} + {13'd0, wr_burst_len};
    assign nxt_end  = nxt_addr + {13'd0, wr_burst_len};

    // ---- FIFO storage (data only, no reset) ----
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_fifo_wr_data;
        end
    end

    // ---- FIFO pointers and fill count ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            num    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            num    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   num <= num + (FIFO_AW + 1)'(1);
                2'b01:   num <= num - (FIFO_AW + 1)'(1);
                default: num <= num;
            endcase
        end
    end

    // ---- Registered read data: word popped on ack appears next cycle ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sdram_wr_data <= '0;
        end else if (pop) begin
            sdram_wr_data <= mem[rd_ptr];
        end
    end

    // ---- Request FSM and burst address ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            sdram_wr_req  <= 1'b0;
            sdram_wr_addr <= '0;
            rst_pend      <= 1'b0;
            addr_load     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // First cycle after reset and any executed wr_rst both
                    // (re)load the window base; neither may start a burst.
                    if (addr_load || flush) begin
                        sdram_wr_addr <= wr_b_addr;
                        addr_load     <= 1'b0;
                        rst_pend      <= 1'b0;
                    end else if (burst_ready) begin
                        state        <= REQ;
                        sdram_wr_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (wr_rst) begin
                        rst_pend <= 1'b1;
                    end
                    if (sdram_wr_end) begin
                        state        <= IDLE;
                        sdram_wr_req <= 1'b0;
                        // Wrap when the following burst would cross the end.
                        if (nxt_end > {1'b0, wr_e_addr}) begin
                            sdram_wr_addr <= wr_b_addr;
                        end else begin
                            sdram_wr_addr <= nxt_addr[20:0];
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    sdram_wr_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef SDRAM_WR_DROP_CNT_EN
    // ---- Saturating count of pushes lost to a full FIFO ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_drop_cnt <= '0;
        end else if (flush) begin
            wr_drop_cnt <= '0;
        end else if (wr_fifo_wr_en && wr_fifo_full && (wr_drop_cnt != 16'hFFFF)) begin
            wr_drop_cnt <= wr_drop_cnt + 16'd1;
        end
    end
`else
    // Without the counter, pushes against a full FIFO are discarded silently.
`endif

endmodule

// File: tb/tb_sdram_wr_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdram_wr_fifo_ctrl
//
// Bench for sdram_wr_fifo_ctrl. A behavioural model (word queue, request flag,
// burst address) is advanced on every rising edge from the same inputs the
// DUT sees, and every DUT output is compared against it one time unit later.
// The bench also plays the burst-write engine: it acks wr_burst_len words on
// consecutive cycles after seeing a request, then pulses sdram_wr_end.
// Define SDRAM_WR_DROP_CNT_EN to include the dropped-push counter.
// ---------------------------------------------------------------------------
module tb_sdram_wr_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_end;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [20:0] b_addr;
    logic [20:0] e_addr;
    logic [8:0]  len;
    logic        wr_rst;
    logic        ack;
    logic        wend;
    logic        full;
    logic [AW:0] num;
    logic        req;
    logic [20:0] addr;
    logic [31:0] data;
`ifdef SDRAM_WR_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 sys_clk = ~sys_clk;

    sdram_wr_fifo_ctrl #(.FIFO_AW(AW)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .init_end       (init_end),
        .wr_fifo_wr_en  (wr_en),
        .wr_fifo_wr_data(wr_data),
        .wr_b_addr      (b_addr),
        .wr_e_addr      (e_addr),
        .wr_burst_len   (len),
        .wr_rst         (wr_rst),
        .sdram_wr_ack   (ack),
        .sdram_wr_end   (wend),
        .wr_fifo_full   (full),
        .wr_fifo_num    (num),
        .sdram_wr_req   (req),
        .sdram_wr_addr  (addr),
        .sdram_wr_data  (data)
`ifdef SDRAM_WR_DROP_CNT_EN
       ,.wr_drop_cnt    (drop_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model state ----
    logic [31:0] q[$];
    bit          m_req;
    bit          m_first;
    bit          m_pend;
    logic [20:0] m_addr;
    logic [31:0] m_data;
    int          m_drop;

    task automatic model_edge();
        int          sz;
        bit          idle;
        bit          do_flush;
        logic [21:0] nxt;
        sz       = q.size();
        idle     = !m_req;
        do_flush = idle && (wr_rst || m_pend);
        if (do_flush) begin
            q.delete();
            m_pend  = 1'b0;
            m_addr  = b_addr;
            m_drop  = 0;
            m_first = 1'b0;
        end else begin
            if (ack && sz != 0) m_data = q.pop_front();
            if (wr_en) begin
                if (sz == DEPTH) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    q.push_back(wr_data);
                end
            end
            if (idle) begin
                if (m_first) begin
                    m_addr  = b_addr;
                    m_first = 1'b0;
                end else if (init_end && len != 0 && sz >= int'(len)) begin
                    m_req = 1'b1;
                end
            end else begin
                if (wr_rst) m_pend = 1'b1;
                if (wend) begin
                    m_req  = 1'b0;
                    nxt    = 22'(m_addr) + 22'(len);
                    m_addr = (int'(nxt) + int'(len) > int'(e_addr)) ? b_addr : nxt[20:0];
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("req",  32'(req),  32'(m_req));
        check_val("addr", 32'(addr), 32'(m_addr));
        check_val("data", data,      m_data);
        check_val("num",  32'(num),  q.size());
        check_val("full", 32'(full), 32'(q.size() == DEPTH));
`ifdef SDRAM_WR_DROP_CNT_EN
        check_val("drop_cnt", 32'(drop_cnt), m_drop);
`endif
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // ---- stimulus / engine state ----
    int          push_left  = 0;
    bit          push_dense = 1'b0;
    logic [31:0] push_vals[$];
    bit          man_ack    = 1'b0;
    bit          man_rst    = 1'b0;
    bit          eng_on     = 1'b0;
    int          eng_st     = 0;
    int          eng_left   = 0;
    int          acks_done  = 0;
    int          eng_bursts = 0;
    bit          rst_trig   = 1'b0;
    logic [20:0] addr_seen[$];

    task automatic tick();
        wr_en   = 1'b0;
        wr_rst  = man_rst;
        man_rst = 1'b0;
        ack     = man_ack;
        wend    = 1'b0;
        if (push_left > 0 && (push_dense || $urandom_range(0, 3) != 0)) begin
            wr_en   = 1'b1;
            wr_data = (push_vals.size() > 0) ? push_vals.pop_front() : $urandom;
            push_left--;
        end
        if (eng_on) begin
            if (rst_trig && eng_st == 1 && acks_done == 3) begin
                wr_rst   = 1'b1;
                rst_trig = 1'b0;
            end
            case (eng_st)
                0: if (req) begin
                    addr_seen.push_back(addr);
                    ack       = 1'b1;
                    acks_done = 1;
                    eng_left  = int'(len) - 1;
                    eng_st    = (eng_left == 0) ? 2 : 1;
                end
                1: begin
                    ack = 1'b1;
                    acks_done++;
                    eng_left--;
                    if (eng_left == 0) eng_st = 2;
                end
                default: begin
                    wend   = 1'b1;
                    eng_st = 0;
                    eng_bursts++;
                end
            endcase
        end
        cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_bursts(input int target, input int limit);
        int c = 0;
        while (eng_bursts < target && c < limit) begin
            tick();
            c++;
        end
        check_val("burst_count", eng_bursts, target);
    endtask

    task automatic run_until_drained(input int limit);
        int c = 0;
        while ((q.size() != 0 || eng_st != 0 || m_req || push_left != 0) && c < limit) begin
            tick();
            c++;
        end
        check_val("drained_num", 32'(num), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        sys_rst_n = 1'b0;
        init_end  = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        b_addr    = 21'h0;
        e_addr    = 21'h000400;
        len       = 9'd8;
        wr_rst    = 1'b0;
        ack       = 1'b0;
        wend      = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_val("rst_req",  32'(req),  0);
        check_val("rst_addr", 32'(addr), 0);
        check_val("rst_data", data,      0);
        check_val("rst_num",  32'(num),  0);
        check_val("rst_full", 32'(full), 0);
`ifdef SDRAM_WR_DROP_CNT_EN
        check_val("rst_drop", 32'(drop_cnt), 0);
`endif
        m_req = 1'b0; m_first = 1'b1; m_pend = 1'b0;
        m_addr = '0; m_data = '0; m_drop = 0;
        sys_rst_n = 1'b1;

        // First burst: words 1..8, request one cycle after the 8th push.
        for (int i = 1; i <= 8; i++) push_vals.push_back(32'(i));
        push_left  = 8;
        push_dense = 1'b1;
        run(8);
        check_val("req_before_rise", 32'(req), 0);
        run(1);
        check_val("req_rise", 32'(req), 1);
        check_val("first_addr", 32'(addr), 0);
        eng_on = 1'b1;
        run_until_bursts(1, 40);
        run_until_drained(20);

        // 129 more bursts back-to-back; addresses step by 8 and wrap at 128.
        push_left = 8 * 129;
        run_until_bursts(130, 129 * 20 + 100);
        run_until_drained(100);
        for (int k = 0; k < 130; k++) begin
            if (k < addr_seen.size())
                check_val("burst_addr", 32'(addr_seen[k]), (k % 128) * 8);
            else
                check_val("burst_addr_missing", addr_seen.size(), 130);
        end

        // Overfill: 1030 pushes with no acks, 6 dropped.
        eng_on    = 1'b0;
        push_left = 1030;
        run(1030);
        check_val("full_flag", 32'(full), 1);
        check_val("full_num",  32'(num),  DEPTH);
`ifdef SDRAM_WR_DROP_CNT_EN
        check_val("drop_six", 32'(drop_cnt), 6);
`endif
        eng_on = 1'b1;
        run_until_drained(2500);

        // Simultaneous push and pop at num=100, len=0 so no request ever.
        eng_on    = 1'b0;
        len       = 9'd0;
        push_left = 100;
        run(100);
        check_val("num_100", 32'(num), 100);
        man_ack   = 1'b1;
        push_left = 20;
        run(20);
        check_val("num_hold_100", 32'(num), 100);
        run(100);
        man_ack = 1'b0;
        check_val("num_empty", 32'(num), 0);
        check_val("len0_no_req", 32'(req), 0);

        // init_end gating.
        len       = 9'd8;
        init_end  = 1'b0;
        push_left = 16;
        run(21);
        check_val("noinit_no_req", 32'(req), 0);
        init_end = 1'b1;
        run(1);
        check_val("init_req", 32'(req), 1);
        eng_on = 1'b1;
        run_until_drained(100);

        // wr_rst mid-burst on a new window.
        b_addr  = 21'h100000;
        e_addr  = 21'h100040;
        man_rst = 1'b1;
        run(1);
        check_val("idle_rst_addr", 32'(addr), 32'h100000);
        b0         = eng_bursts;
        rst_trig   = 1'b1;
        push_dense = 1'b0;
        push_left  = 12;
        run_until_bursts(b0 + 1, 80);
        check_val("rst_full_burst", acks_done, 8);
        run(2);
        check_val("flush_num",  32'(num),  0);
        check_val("flush_addr", 32'(addr), 32'h100000);
        check_val("flush_req",  32'(req),  0);
        push_dense = 1'b1;
        push_left  = 7;
        run(12);
        check_val("seven_no_req", 32'(req), 0);
        push_left = 1;
        run_until_bursts(b0 + 2, 40);
        check_val("post_rst_addr", 32'(addr_seen[addr_seen.size() - 1]), 32'h100000);
        run_until_drained(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
